// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame config and host handshake of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       read;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       perr;
  logic       ferr;
  logic       ovf;
  modport slave (input rx, eight, pen, ohel, read, output rx_data, rx_ready, perr, ferr, ovf);
  modport master (output rx, eight, pen, ohel, read, input rx_data, rx_ready, perr, ferr, ovf);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, 7/8 data bits, optional odd/even parity, ready/overrun flags
module uart_rx #(
  parameter int BAUD_DIV = 5208
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  logic        sync_q, rx_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic [2:0]  cfg_q, cfg_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic        tick, last, done;
  logic [7:0]  data_new;
  always_comb begin
    tick     = cnt_q == (state_q == START ? HALF : FULL);
    last     = bit_q == (cfg_q[2] ? 3'd7 : 3'd6);
    done     = state_q == STOP && tick;
    data_new = cfg_q[2] ? sh_q : {1'b0, sh_q[7:1]};
    state_d  = state_q;
    cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_d    = par_q;
    cfg_d    = cfg_q;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (!rx_s_q) begin
          state_d = START;
          cfg_d   = {bus.eight, bus.pen, bus.ohel};
          sh_d    = 8'd0;
          bit_d   = 3'd0;
        end
      end
      START: if (tick) state_d = rx_s_q ? IDLE : DATA;
      DATA: if (tick) begin
        sh_d  = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (last) state_d = cfg_q[1] ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        par_d   = rx_s_q;
        state_d = STOP;
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_d = done ? data_new : data_q;
    perr_d = done ? cfg_q[1] & (^data_new ^ par_q ^ cfg_q[0]) : perr_q;
    ferr_d = done ? ~rx_s_q : ferr_q;
    rdy_d  = done | (rdy_q & ~bus.read);
    ovf_d  = done ? rdy_q & ~bus.read : ovf_q & ~(rdy_q & bus.read);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      par_q   <= 1'b0;
      cfg_q   <= 3'd0;
      data_q  <= 8'd0;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= bus.rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      cfg_q   <= cfg_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.rx_data  = data_q;
  assign bus.rx_ready = rdy_q;
  assign bus.perr     = perr_q;
  assign bus.ferr     = ferr_q;
  assign bus.ovf      = ovf_q;
endmodule
